// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory AXI refill engine.
//   - default line size (words), refill FSM state encoding
//   - AXI4 constants for INCR bursts of 32-bit beats
//   - line offset width helper (byte offset bits inside one line)
package imem_pkg;

    localparam int unsigned CACHE_SIZE_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AR      = 2'd1,
        ST_DATA    = 2'd2,
        ST_PRESENT = 2'd3
    } refill_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Number of byte-offset bits covered by a line of 'words' 32-bit words.
    function automatic int unsigned line_off_w(input int unsigned words);
        return $clog2(words * 4);
    endfunction

endpackage

// File: rtl/imem_axi_refill_ack_sync.sv
// ack_sync: brings the mem_clk-domain line acknowledge into axi_clk.
//   axi_clk  in  : destination clock
//   i_rstn   in  : asynchronous active-low reset, all flops clear to 0
//   i_ack    in  : asynchronous acknowledge level/pulse
//   o_rise   out : one axi_clk cycle high on a rising edge of the synchronized ack
module ack_sync (
    input  logic axi_clk,
    input  logic i_rstn,
    input  logic i_ack,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_ack;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/imem_axi_refill.sv
// imem_axi_refill: fetches one instruction-cache line over AXI4 as
// CACHE_SIZE/BURST_LEN INCR bursts, assembles it in a line buffer and
// presents it (with its base address) until the consumer acknowledges.
//   axi_clk, i_rstn                    : clock, async active-low reset
//   axi_rd_rq, axi_rd_addr             : refill request pulse + line base
//   axi_rd_valid, axi_rd_valid_addr    : line complete, its base address
//   axi_rd_data                        : line buffer, word i = base+4i
//   axi_rd_valid_ack                   : mem_clk-domain acknowledge pulse
//   arvalid..arburst / rvalid..rlast   : AXI4 AR and R channels
//   rd_err                             : sticky response/rlast error flag
// Build option: IMEM_REFILL_PEND_EN adds a one-deep pending request that
// captures requests arriving outside IDLE; without it they are ignored.
module imem_axi_refill
    import imem_pkg::*;
#(
    parameter int unsigned CACHE_SIZE = CACHE_SIZE_DEF,
    parameter int unsigned BURST_LEN  = 256
) (
    input  logic                         axi_clk,
    input  logic                         i_rstn,
    input  logic                         axi_rd_rq,
    input  logic [31:0]                  axi_rd_addr,
    output logic                         axi_rd_valid,
    output logic [31:0]                  axi_rd_valid_addr,
    output logic [CACHE_SIZE-1:0][31:0]  axi_rd_data,
    input  logic                         axi_rd_valid_ack,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    output logic                         rd_err
);

    localparam int unsigned NBURST      = CACHE_SIZE / BURST_LEN;
    localparam int unsigned WW          = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;
    localparam int unsigned BW          = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int unsigned LW          = $clog2(BURST_LEN) + 1;
    localparam int unsigned OFFW        = line_off_w(CACHE_SIZE);
    localparam logic [31:0] OFF_MASK    = 32'((64'd1 << OFFW) - 64'd1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_AR      = ST_AR;
    localparam logic [1:0] S_DATA    = ST_DATA;
    localparam logic [1:0] S_PRESENT = ST_PRESENT;

    logic [1:0]                  r_state;
    logic [31:0]                 r_base;
    logic [31:0]                 r_araddr;
    logic                        r_arvalid;
    logic                        r_rready;
    logic [BW-1:0]               r_bcnt;
    logic [WW-1:0]               r_wcnt;
    logic [LW-1:0]               r_beat;
    logic                        r_valid;
    logic [31:0]                 r_valid_addr;
    logic                        r_err;
    logic [CACHE_SIZE-1:0][31:0] r_line;

    logic        w_ack_rise;
    logic        w_start;
    logic [31:0] w_start_addr;
    logic        w_beat;
    logic        w_full;
    logic        w_burst_end;
    logic        w_beat_err;

    ack_sync u_ack_sync (
        .axi_clk (axi_clk),
        .i_rstn  (i_rstn),
        .i_ack   (axi_rd_valid_ack),
        .o_rise  (w_ack_rise)
    );

`ifdef IMEM_REFILL_PEND_EN
    logic        r_pend;
    logic [31:0] r_pend_addr;

    // A live request in IDLE wins over (and retires) the pending one.
    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (axi_rd_rq && (r_state != S_IDLE)) begin
            r_pend      <= 1'b1;
            r_pend_addr <= axi_rd_addr;
        end else if (w_start) begin
            r_pend      <= 1'b0;
        end
    end

    assign w_start      = (r_state == S_IDLE) && (axi_rd_rq || r_pend);
    assign w_start_addr = (axi_rd_rq ? axi_rd_addr : r_pend_addr) & ~OFF_MASK;
`else
    assign w_start      = (r_state == S_IDLE) && axi_rd_rq;
    assign w_start_addr = axi_rd_addr & ~OFF_MASK;
`endif

    // Beat position is tracked per burst so an early rlast does not skew
    // the check of later bursts.
    assign w_beat      = (r_state == S_DATA) && rvalid;
    assign w_full      = (r_beat == LW'(BURST_LEN - 1));
    assign w_burst_end = rlast || w_full;
    assign w_beat_err  = w_beat && ((rresp != RESP_OKAY) || (rlast != w_full));

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_bcnt       <= '0;
            r_wcnt       <= '0;
            r_beat       <= '0;
            r_valid      <= 1'b0;
            r_valid_addr <= '0;
            r_err        <= 1'b0;
            r_line       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_base    <= w_start_addr;
                        r_araddr  <= w_start_addr;
                        r_arvalid <= 1'b1;
                        r_bcnt    <= '0;
                        r_wcnt    <= '0;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rvalid) begin
                        r_line[r_wcnt] <= rdata;
                        r_wcnt         <= r_wcnt + 1'b1;
                        r_beat         <= r_beat + 1'b1;
                        if (w_burst_end) begin
                            r_rready <= 1'b0;
                            if (r_bcnt == BW'(NBURST - 1)) begin
                                r_valid      <= 1'b1;
                                r_valid_addr <= r_base;
                                r_state      <= S_PRESENT;
                            end else begin
                                r_bcnt    <= r_bcnt + 1'b1;
                                r_araddr  <= r_base + (32'(r_bcnt) + 32'd1) * BURST_BYTES;
                                r_arvalid <= 1'b1;
                                r_state   <= S_AR;
                            end
                        end
                    end
                end
                S_PRESENT: begin
                    if (w_ack_rise) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign arvalid           = r_arvalid;
    assign araddr            = r_araddr;
    assign arlen             = 8'(BURST_LEN - 1);
    assign arsize            = SIZE_4B;
    assign arburst           = BURST_INCR;
    assign rready            = r_rready;
    assign axi_rd_valid      = r_valid;
    assign axi_rd_valid_addr = r_valid_addr;
    assign axi_rd_data       = r_line;
    assign rd_err            = r_err;

endmodule

// File: tb/tb_imem_axi_refill.sv
module tb_imem_axi_refill;

    localparam int CS = 16;
    localparam int BL = 8;

    logic                 axi_clk;
    logic                 mem_clk;
    logic                 i_rstn;
    logic                 axi_rd_rq;
    logic [31:0]          axi_rd_addr;
    logic                 axi_rd_valid;
    logic [31:0]          axi_rd_valid_addr;
    logic [CS-1:0][31:0]  axi_rd_data;
    logic                 axi_rd_valid_ack;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 rvalid;
    logic                 rready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rd_err;

    imem_axi_refill #(.CACHE_SIZE(CS), .BURST_LEN(BL)) dut (
        .axi_clk           (axi_clk),
        .i_rstn            (i_rstn),
        .axi_rd_rq         (axi_rd_rq),
        .axi_rd_addr       (axi_rd_addr),
        .axi_rd_valid      (axi_rd_valid),
        .axi_rd_valid_addr (axi_rd_valid_addr),
        .axi_rd_data       (axi_rd_data),
        .axi_rd_valid_ack  (axi_rd_valid_ack),
        .arvalid           (arvalid),
        .arready           (arready),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .rvalid            (rvalid),
        .rready            (rready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rd_err            (rd_err)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    // mem_clk is 3x slower, edges offset from axi_clk edges
    initial begin
        mem_clk = 1'b0;
        #2;
        forever #15 mem_clk = ~mem_clk;
    end

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]         addr;
        logic                err;
        logic [CS-1:0][31:0] data;
    } line_t;

    logic [31:0] exp_ar[$];
    line_t       exp_line[$];
    int          exp_drop[$];

    logic [CS-1:0][31:0] m_line;
    int                  m_wcnt;
    logic                m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic                prev_valid  = 1'b0;
    logic                prev_arwait = 1'b0;
    logic [31:0]         prev_araddr = '0;
    int                  last_beat_cyc = 0;
    logic [CS-1:0][31:0] snap_data;
    logic [31:0]         snap_addr;

    always @(negedge axi_clk) begin
        line_t       el;
        logic [31:0] ea;
        int          ed;
        if (!i_rstn) begin
            prev_valid  = 1'b0;
            prev_arwait = 1'b0;
        end else begin
            if (prev_arwait && arvalid) chk("araddr_stable", araddr, prev_araddr);
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) fail_note("unexpected_ar");
                else begin
                    ea = exp_ar.pop_front();
                    chk("araddr", araddr, ea);
                    chk("arlen", {24'd0, arlen}, 32'd7);
                    chk("arsize_arburst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
                end
            end
            prev_arwait = arvalid && !arready;
            prev_araddr = araddr;
            if (rvalid && rready) last_beat_cyc = cyc;

            if (axi_rd_valid && !prev_valid) begin
                if (exp_line.size() == 0) fail_note("unexpected_valid");
                else begin
                    el = exp_line.pop_front();
                    chk("valid_addr", axi_rd_valid_addr, el.addr);
                    chk("rd_err", {31'd0, rd_err}, {31'd0, el.err});
                    for (int i = 0; i < CS; i++)
                        chk($sformatf("line_word%0d", i), axi_rd_data[i], el.data[i]);
                    chk("valid_latency", cyc, last_beat_cyc + 1);
                end
                snap_data = axi_rd_data;
                snap_addr = axi_rd_valid_addr;
            end else if (axi_rd_valid && prev_valid) begin
                chk("line_hold", {31'd0, (axi_rd_data == snap_data) && (axi_rd_valid_addr == snap_addr)}, 32'd1);
            end else if (!axi_rd_valid && prev_valid) begin
                if (exp_drop.size() == 0) fail_note("unexpected_drop");
                else begin
                    ed = exp_drop.pop_front();
                    chk("drop_cycle", cyc, ed);
                end
            end
            prev_valid = axi_rd_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic request(input logic [31:0] a);
        axi_rd_rq   = 1'b1;
        axi_rd_addr = a;
        tick();
        axi_rd_rq   = 1'b0;
    endtask

    task automatic ar_accept(input int stall);
        int n = 0;
        while (arvalid !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin fail_note("ar_timeout"); return; end
        repeat (stall) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rready_after_ar", {31'd0, rready}, 32'd1);
    endtask

    task automatic r_burst(input logic [31:0] a0, input int nbeats, input bit gaps,
                           input int resp_beat, input int last_idx);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && (b % 2 == 1)) begin rvalid = 1'b0; tick(); tick(); end
            rvalid = 1'b1;
            rdata  = a0 + 32'(4 * b);
            rresp  = (b == resp_beat) ? 2'b10 : 2'b00;
            rlast  = (b == last_idx);
            n = 0;
            while (rready !== 1'b1 && n < 50) begin tick(); n++; end
            if (n >= 50) begin fail_note("rready_timeout"); rvalid = 1'b0; return; end
            tick();
            if (m_wcnt < CS) m_line[m_wcnt] = a0 + 32'(4 * b);
            m_wcnt++;
            if (b == resp_beat || ((b == last_idx) != (b == BL - 1))) m_err = 1'b1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic expect_line(input logic [31:0] base);
        line_t l;
        l.addr = base;
        l.err  = m_err;
        l.data = m_line;
        exp_line.push_back(l);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (axi_rd_valid !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) fail_note("valid_timeout");
    endtask

    task automatic ack_pulse();
        @(posedge mem_clk);
        axi_rd_valid_ack = 1'b1;
        exp_drop.push_back(cyc + 3);
        @(posedge mem_clk);
        axi_rd_valid_ack = 1'b0;
    endtask

    task automatic wait_drop();
        int n = 0;
        while (axi_rd_valid !== 1'b0 && n < 50) begin tick(); n++; end
        if (n >= 50) fail_note("drop_timeout");
    endtask

    // simple two-burst line with rdata = address
    task automatic plain_line(input logic [31:0] base);
        m_wcnt = 0;
        exp_ar.push_back(base);
        exp_ar.push_back(base + 32'h20);
        ar_accept(0);
        r_burst(base, BL, 1'b0, -1, BL - 1);
        ar_accept(0);
        r_burst(base + 32'h20, BL, 1'b0, -1, BL - 1);
        expect_line(base);
        wait_valid();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        i_rstn = 1'b0; axi_rd_rq = 1'b0; axi_rd_addr = '0; axi_rd_valid_ack = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        m_line = '0; m_wcnt = 0; m_err = 1'b0;
        repeat (3) tick();

        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_valid", {31'd0, axi_rd_valid}, 32'd0);
        chk("rst_valid_addr", axi_rd_valid_addr, 32'd0);
        chk("rst_rd_err", {31'd0, rd_err}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_line_zero", {31'd0, axi_rd_data == '0}, 32'd1);
        i_rstn = 1'b1;
        tick();

        // 1: basic refill, rq -> arvalid next cycle
        request(32'h0000_1040);
        chk("rq_to_arvalid", {31'd0, arvalid}, 32'd1);
        plain_line(32'h0000_1040);
        for (int i = 0; i < CS; i++)
            chk($sformatf("t1_word%0d", i), axi_rd_data[i], 32'h0000_1040 + 32'(4 * i));
        ack_pulse();
        wait_drop();

        // 2: arready stalls and rvalid gaps
        request(32'h0000_2080);
        m_wcnt = 0;
        exp_ar.push_back(32'h0000_2080);
        exp_ar.push_back(32'h0000_20A0);
        ar_accept(5);
        r_burst(32'h0000_2080, BL, 1'b1, -1, BL - 1);
        ar_accept(3);
        r_burst(32'h0000_20A0, BL, 1'b1, -1, BL - 1);
        expect_line(32'h0000_2080);
        wait_valid();
        ack_pulse();
        wait_drop();

        // 3: SLVERR on third beat
        request(32'h0000_3000);
        m_wcnt = 0;
        exp_ar.push_back(32'h0000_3000);
        exp_ar.push_back(32'h0000_3020);
        ar_accept(0);
        r_burst(32'h0000_3000, BL, 1'b0, 2, BL - 1);
        ar_accept(0);
        r_burst(32'h0000_3020, BL, 1'b0, -1, BL - 1);
        expect_line(32'h0000_3000);
        wait_valid();
        ack_pulse();
        wait_drop();

        // 4: early rlast on the fifth beat
        request(32'h0000_3040);
        m_wcnt = 0;
        exp_ar.push_back(32'h0000_3040);
        exp_ar.push_back(32'h0000_3060);
        ar_accept(0);
        r_burst(32'h0000_3040, 5, 1'b0, -1, 4);
        ar_accept(0);
        r_burst(32'h0000_3060, BL, 1'b0, -1, BL - 1);
        expect_line(32'h0000_3040);
        wait_valid();
        ack_pulse();
        wait_drop();

        // 5: second request while the line is presented
        request(32'h0000_4000);
        plain_line(32'h0000_4000);
        request(32'h0000_5000);
`ifdef IMEM_REFILL_PEND_EN
        ack_pulse();
        wait_drop();
        chk("pend_arvalid_at_drop", {31'd0, arvalid}, 32'd0);
        tick();
        chk("pend_arvalid_after_drop", {31'd0, arvalid}, 32'd1);
        plain_line(32'h0000_5000);
        ack_pulse();
        wait_drop();
`else
        ack_pulse();
        wait_drop();
        seen = 0;
        repeat (10) begin tick(); if (arvalid) seen++; end
        chk("ignored_rq_no_ar", seen, 0);
`endif

        // 6: reset in the middle of DATA, then a clean refill
        request(32'h0000_6000);
        m_wcnt = 0;
        exp_ar.push_back(32'h0000_6000);
        ar_accept(0);
        r_burst(32'h0000_6000, 3, 1'b0, -1, -1);
        #3;
        i_rstn = 1'b0;
        #1;
        chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("arst_rready", {31'd0, rready}, 32'd0);
        chk("arst_valid", {31'd0, axi_rd_valid}, 32'd0);
        chk("arst_valid_addr", axi_rd_valid_addr, 32'd0);
        chk("arst_rd_err", {31'd0, rd_err}, 32'd0);
        chk("arst_araddr", araddr, 32'd0);
        chk("arst_line_zero", {31'd0, axi_rd_data == '0}, 32'd1);
        m_line = '0;
        m_err  = 1'b0;
        repeat (2) tick();
        i_rstn = 1'b1;
        tick();
        request(32'h0000_0400);
        plain_line(32'h0000_0400);
        ack_pulse();
        wait_drop();
        repeat (3) tick();

        chk("exp_ar_drained", exp_ar.size(), 0);
        chk("exp_line_drained", exp_line.size(), 0);
        chk("exp_drop_drained", exp_drop.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
